// File: rtl/apu_frame_sequencer.sv
// APU frame sequencer: divides apu_clk into quarter/half-frame strobes (4-step / 5-step modes).
// Optional frame interrupt is built only when APU_FRAME_IRQ_EN is defined.
module apu_frame_sequencer #(
    parameter int STEP_CYCLES = 3729
) (
    input  logic       apu_clk,
    input  logic       rst_n,
    input  logic       cfg_wr,
    input  logic [1:0] cfg_data,
    input  logic       irq_ack,
    output logic       qtr_clk,
    output logic       hlf_clk,
    output logic       frame_irq,
    output logic [2:0] step_index
);

    localparam int DIV_W = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(STEP_CYCLES - 1);

    logic [DIV_W-1:0] r_div;
    logic [2:0]       r_step;
    logic             r_mode;
    logic             r_qtr;
    logic             r_hlf;

    logic [DIV_W-1:0] w_div_nxt;
    logic [2:0]       w_step_nxt;
    logic             w_qtr_nxt;
    logic             w_hlf_nxt;
    logic             w_tc;
    logic             w_evt;
    logic             w_last;
    logic             w_step3_4;

    always_comb begin
        w_tc       = (r_div == DIV_LAST);
        // A register write on the terminal count swallows that step event.
        w_evt      = w_tc && !cfg_wr;
        w_last     = r_mode ? (r_step == 3'd4) : (r_step == 3'd3);
        w_step3_4  = (!r_mode && (r_step == 3'd3));
        w_div_nxt  = w_tc ? '0 : r_div + DIV_W'(1);
        w_step_nxt = r_step;
        w_qtr_nxt  = 1'b0;
        w_hlf_nxt  = 1'b0;
        if (cfg_wr) begin
            w_div_nxt  = '0;
            w_step_nxt = 3'd0;
            w_qtr_nxt  = cfg_data[1];
            w_hlf_nxt  = cfg_data[1];
        end else if (w_evt) begin
            w_step_nxt = w_last ? 3'd0 : r_step + 3'd1;
            w_qtr_nxt  = !(r_mode && (r_step == 3'd3));
            w_hlf_nxt  = (r_step == 3'd1) || (r_mode && (r_step == 3'd4)) || w_step3_4;
        end
    end

    always_ff @(posedge apu_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div  <= '0;
            r_step <= 3'd0;
            r_mode <= 1'b0;
            r_qtr  <= 1'b0;
            r_hlf  <= 1'b0;
        end else begin
            r_div  <= w_div_nxt;
            r_step <= w_step_nxt;
            r_qtr  <= w_qtr_nxt;
            r_hlf  <= w_hlf_nxt;
            if (cfg_wr) begin
                r_mode <= cfg_data[1];
            end
        end
    end

`ifdef APU_FRAME_IRQ_EN
    logic r_irq_inh;
    logic r_irq;
    logic w_irq_set;

    // Set has priority over both acknowledge and an inhibiting write.
    assign w_irq_set = w_evt && w_step3_4 && !r_irq_inh;

    always_ff @(posedge apu_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_irq_inh <= 1'b0;
            r_irq     <= 1'b0;
        end else begin
            if (cfg_wr) begin
                r_irq_inh <= cfg_data[0];
            end
            if (w_irq_set) begin
                r_irq <= 1'b1;
            end else if ((cfg_wr && cfg_data[0]) || irq_ack) begin
                r_irq <= 1'b0;
            end
        end
    end

    assign frame_irq = r_irq;
`else
    logic w_unused_irq;
    assign w_unused_irq = ^{irq_ack, cfg_data[0]};
    assign frame_irq    = 1'b0;
`endif

    assign qtr_clk    = r_qtr;
    assign hlf_clk    = r_hlf;
    assign step_index = r_step;

endmodule
